// File: rtl/cl_div_seq_if.sv
// cl_div_seq_if: handshake and operand/result bundle for the carry-less divider.
//   master: issues start/cancel and operands, observes busy/valid and results.
//   slave:  the divider side.
// Signals: start, cancel, dividend, divisor (to divider);
//          busy, valid, quotient, remainder, div_zero (from divider).
interface cl_div_seq_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  start;
  logic                  cancel;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  busy;
  logic                  valid;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_zero;

  modport master (
    output start, cancel, dividend, divisor,
    input  busy, valid, quotient, remainder, div_zero
  );

  modport slave (
    input  start, cancel, dividend, divisor,
    output busy, valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/cl_div_seq.sv
// cl_div_seq: bit-serial GF(2)[x] polynomial divider, one quotient bit per cycle, MSB first.
// dividend = clmul(quotient, divisor) ^ remainder, deg(remainder) < deg(divisor).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - cl_div_seq_if.slave: start/cancel/dividend/divisor in,
//          busy/valid/quotient/remainder/div_zero out
module cl_div_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  cl_div_seq_if.slave bus
);
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, d_q, r_q, q_q, mask_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] quotient_q, remainder_q;
  logic                  div_zero_q;

  logic [DATA_WIDTH-1:0] lead_mask;
  logic [DATA_WIDTH-1:0] r_shift, r_next, q_next;
  logic                  q_bit, accept, last, div_by_zero;

  // One-hot mask of the divisor's leading 1; highest set bit wins.
  always_comb begin
    lead_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (bus.divisor[i]) begin
        lead_mask    = '0;
        lead_mask[i] = 1'b1;
      end
    end
  end

  assign div_by_zero = (bus.divisor == '0);
  assign accept      = bus.start && !bus.cancel && (state_q != StCalc);
  assign last        = (cnt_q == '0);

  // Shift the next dividend bit into R; subtract (XOR) D when R reaches deg(D).
  assign r_shift = (r_q << 1) | {{(DATA_WIDTH-1){1'b0}}, a_q[DATA_WIDTH-1]};
  assign q_bit   = |(r_shift & mask_q);
  assign r_next  = q_bit ? (r_shift ^ d_q) : r_shift;
  assign q_next  = (q_q << 1) | {{(DATA_WIDTH-1){1'b0}}, q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = div_by_zero ? StDone : StCalc;
      end
      StCalc: begin
        if (bus.cancel) state_d = StIdle;
        else if (last)  state_d = StDone;
      end
      StDone: begin
        if (accept) state_d = div_by_zero ? StDone : StCalc;
        else        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.dividend;
      d_q    <= bus.divisor;
      r_q    <= '0;
      q_q    <= '0;
      mask_q <= lead_mask;
      cnt_q  <= CntW'(DATA_WIDTH - 1);
      // Zero divisor completes on the capture edge itself.
      if (div_by_zero) begin
        quotient_q  <= '1;
        remainder_q <= bus.dividend;
        div_zero_q  <= 1'b1;
      end
    end else if ((state_q == StCalc) && !bus.cancel) begin
      a_q   <= a_q << 1;
      r_q   <= r_next;
      q_q   <= q_next;
      cnt_q <= cnt_q - CntW'(1);
      if (last) begin
        quotient_q  <= q_next;
        remainder_q <= r_next;
        div_zero_q  <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state_q == StCalc);
  assign bus.valid     = (state_q == StDone);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_cl_div_seq.sv
// Self-checking bench for cl_div_seq: 8-bit directed scenarios and 32-bit random ops
// against a long-division reference model.
module tb_cl_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cl_div_seq_if #(.DATA_WIDTH(8))  bus8 ();
  cl_div_seq_if #(.DATA_WIDTH(32)) bus32 ();

  cl_div_seq #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  cl_div_seq #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32)
  );

  // ---------------- reference model ----------------
  function automatic int deg(input logic [63:0] x);
    int d = -1;
    for (int i = 0; i < 64; i++) if (x[i]) d = i;
    return d;
  endfunction

  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'h0, a} << i);
    return p;
  endfunction

  // Schoolbook polynomial long division; divisor must be non-zero.
  function automatic void ref_div(input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r);
    int dd = deg({32'h0, d});
    q = '0;
    r = n;
    for (int i = 31 - dd; i >= 0; i--) begin
      if (r[i+dd]) begin
        r    = r ^ (d << i);
        q[i] = 1'b1;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; returns in the valid cycle. lat = edges after accept edge until valid.
  task automatic op8(input logic [7:0] dvd, input logic [7:0] dvs, output int lat,
                     output int bc);
    bus8.dividend = dvd;
    bus8.divisor  = dvs;
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!bus8.valid && lat < 200) begin
      if (bus8.busy) bc++;
      tick();
      lat++;
    end
  endtask

  task automatic op32(input logic [31:0] dvd, input logic [31:0] dvs, output int lat);
    bus32.dividend = dvd;
    bus32.divisor  = dvs;
    bus32.start    = 1'b1;
    tick();
    bus32.start = 1'b0;
    lat = 0;
    while (!bus32.valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bus8.busy, bus8.valid, bus8.quotient, bus8.remainder, bus8.div_zero} !== '0) begin
      bad++;
      $display("FAIL reset8: got busy=%b valid=%b q=%h r=%h dz=%b want all 0", bus8.busy,
               bus8.valid, bus8.quotient, bus8.remainder, bus8.div_zero);
    end
    total++;
    if ({bus32.busy, bus32.valid, bus32.quotient, bus32.remainder, bus32.div_zero} !== '0) begin
      bad++;
      $display("FAIL reset32: got busy=%b valid=%b q=%h r=%h dz=%b want all 0", bus32.busy,
               bus32.valid, bus32.quotient, bus32.remainder, bus32.div_zero);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] dvd [5] = '{8'h57, 8'hFF, 8'h05, 8'hA5, 8'h3C};
    logic [7:0] dvs [5] = '{8'h03, 8'h80, 8'h11, 8'h01, 8'h00};
    logic [7:0] eq  [5] = '{8'h32, 8'h01, 8'h00, 8'hA5, 8'hFF};
    logic [7:0] er  [5] = '{8'h01, 8'h7F, 8'h05, 8'h00, 8'h3C};
    int lat, bc, elat;
    for (int i = 0; i < 5; i++) begin
      op8(dvd[i], dvs[i], lat, bc);
      elat = (dvs[i] == 8'h00) ? 0 : 8;
      total++;
      if (bus8.quotient !== eq[i] || bus8.remainder !== er[i]) begin
        bad++;
        $display("FAIL directed_result[%0d]: got q=%h r=%h want q=%h r=%h", i,
                 bus8.quotient, bus8.remainder, eq[i], er[i]);
      end
      total++;
      if (bus8.div_zero !== (dvs[i] == 8'h00)) begin
        bad++;
        $display("FAIL directed_dz[%0d]: got %b want %b", i, bus8.div_zero, dvs[i] == 8'h00);
      end
      total++;
      if (lat != elat || bc != elat) begin
        bad++;
        $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d want lat=%0d busy=%0d", i,
                 lat, bc, elat, elat);
      end
      tick();
      total++;
      if (bus8.valid !== 1'b0) begin
        bad++;
        $display("FAIL directed_pulse[%0d]: got valid=%b want 0", i, bus8.valid);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    bus8.dividend = 8'h57;
    bus8.divisor  = 8'h03;
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    bus8.dividend = 8'hFF;
    bus8.divisor  = 8'h80;
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    n = 2;
    while (!bus8.valid && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n != 8 || bus8.quotient !== 8'h32 || bus8.remainder !== 8'h01) begin
      bad++;
      $display("FAIL busy_ignore: got lat=%0d q=%h r=%h want lat=8 q=32 r=01", n,
               bus8.quotient, bus8.remainder);
    end
    tick();
  endtask

  task automatic test_cancel();
    int lat, bc, seen;
    op8(8'hA5, 8'h01, lat, bc);
    tick();
    bus8.dividend = 8'h57;
    bus8.divisor  = 8'h03;
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    total++;
    if (bus8.busy !== 1'b1) begin
      bad++;
      $display("FAIL cancel_busy_before: got busy=%b want 1", bus8.busy);
    end
    bus8.cancel   = 1'b1;
    bus8.start    = 1'b1;
    bus8.dividend = 8'hFF;
    bus8.divisor  = 8'h80;
    tick();
    bus8.cancel = 1'b0;
    bus8.start  = 1'b0;
    total++;
    if (bus8.busy !== 1'b0 || bus8.valid !== 1'b0) begin
      bad++;
      $display("FAIL cancel_idle: got busy=%b valid=%b want 0 0", bus8.busy, bus8.valid);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.valid || bus8.busy) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL cancel_quiet: got %0d busy/valid cycles want 0", seen);
    end
    total++;
    if (bus8.quotient !== 8'hA5 || bus8.remainder !== 8'h00 || bus8.div_zero !== 1'b0) begin
      bad++;
      $display("FAIL cancel_hold: got q=%h r=%h dz=%b want q=a5 r=00 dz=0", bus8.quotient,
               bus8.remainder, bus8.div_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, n, hold;
    op8(8'hFF, 8'h80, lat, bc);
    total++;
    if (bus8.quotient !== 8'h01 || bus8.remainder !== 8'h7F) begin
      bad++;
      $display("FAIL b2b_first: got q=%h r=%h want q=01 r=7f", bus8.quotient, bus8.remainder);
    end
    bus8.dividend = 8'h05;
    bus8.divisor  = 8'h11;
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    n    = 1;
    hold = 0;
    while (!bus8.valid && n < 200) begin
      if (bus8.quotient !== 8'h01 || bus8.remainder !== 8'h7F) hold++;
      tick();
      n++;
    end
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles between valids want 9", n);
    end
    total++;
    if (hold != 0) begin
      bad++;
      $display("FAIL b2b_hold: got %0d cycles with changed results want 0", hold);
    end
    total++;
    if (bus8.quotient !== 8'h00 || bus8.remainder !== 8'h05) begin
      bad++;
      $display("FAIL b2b_second: got q=%h r=%h want q=00 r=05", bus8.quotient, bus8.remainder);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int lat, bc, seen;
    op8(8'h3C, 8'h00, lat, bc);
    tick();
    bus8.dividend = 8'h57;
    bus8.divisor  = 8'h03;
    bus8.start    = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus8.busy, bus8.valid, bus8.quotient, bus8.remainder, bus8.div_zero} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b valid=%b q=%h r=%h dz=%b want all 0", bus8.busy,
               bus8.valid, bus8.quotient, bus8.remainder, bus8.div_zero);
    end
    #2;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.valid || bus8.busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL async_reset_quiet: got %0d busy/valid cycles want 0", seen);
    end
  endtask

  task automatic test_random32();
    logic [31:0] dvd, dvs, eq, er;
    logic [63:0] recon;
    int lat;
    for (int i = 0; i < 40; i++) begin
      dvd = $urandom;
      dvs = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 7) dvs = '0;
      if (dvs == '0) begin
        eq = '1;
        er = dvd;
      end else begin
        ref_div(dvd, dvs, eq, er);
      end
      op32(dvd, dvs, lat);
      total++;
      if (bus32.quotient !== eq || bus32.remainder !== er || bus32.div_zero !== (dvs == '0))
      begin
        bad++;
        $display("FAIL rand_result[%0d] %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i,
                 dvd, dvs, bus32.quotient, bus32.remainder, bus32.div_zero, eq, er,
                 dvs == '0);
      end
      total++;
      if (lat != ((dvs == '0) ? 0 : 32)) begin
        bad++;
        $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, (dvs == '0) ? 0 : 32);
      end
      if (dvs != '0) begin
        recon = clmul(bus32.quotient, dvs) ^ {32'h0, bus32.remainder};
        total++;
        if (recon !== {32'h0, dvd} || deg({32'h0, bus32.remainder}) >= deg({32'h0, dvs}))
        begin
          bad++;
          $display("FAIL rand_identity[%0d]: got recon=%h deg_r=%0d want %h deg_r<%0d", i,
                   recon, deg({32'h0, bus32.remainder}), dvd, deg({32'h0, dvs}));
        end
      end
      tick();
    end
  endtask

  initial begin
    bus8.start     = 1'b0;
    bus8.cancel    = 1'b0;
    bus8.dividend  = '0;
    bus8.divisor   = '0;
    bus32.start    = 1'b0;
    bus32.cancel   = 1'b0;
    bus32.dividend = '0;
    bus32.divisor  = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_random32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
